// File: rtl/pipeline_scoreboard.sv
// Hazard / forwarding scoreboard for the instruction in ID.
// Tracks DEPTH in-flight results past ID and picks stall or forward.
module pipeline_scoreboard #(
    parameter int REG_W    = 4,
    parameter int DEPTH    = 2,
    parameter int FWD_EN   = 1,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16,
    parameter int SEL_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_use_src1,
    input  logic             id_two_src,
    input  logic             id_wb_en,
    input  logic             id_mem_read,
    input  logic [REG_W-1:0] id_dest,
    input  logic             br_taken,
    input  logic             mem_stall,
    output logic             hazard,
    output logic [SEL_W-1:0] fwd_sel1,
    output logic [SEL_W-1:0] fwd_sel2,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] freeze_cnt
);

    logic [DEPTH-1:0]            s_valid;
    logic [DEPTH-1:0]            s_wb;
    logic [DEPTH-1:0]            s_mr;
    logic [DEPTH-1:0][REG_W-1:0] s_dest;

    logic [1:0][DEPTH-1:0] hit;
    logic [1:0][SEL_W-1:0] sel;
    logic                  found;

    // Per-slot register matches for each source of the ID instruction
    always_comb begin
        hit = '0;
        for (int k = 0; k < DEPTH; k++) begin
            hit[0][k] = id_valid & id_use_src1 & s_valid[k] & s_wb[k]
                      & (s_dest[k] == id_src1);
            hit[1][k] = id_valid & id_two_src & s_valid[k] & s_wb[k]
                      & (s_dest[k] == id_src2);
        end
    end

    // Youngest matching slot decides: forward it, or stall if not ready
    always_comb begin
        hazard = 1'b0;
        sel    = '0;
        found  = 1'b0;
        for (int s = 0; s < 2; s++) begin
            found = 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                if (!found && hit[s][k]) begin
                    found = 1'b1;
                    if (FWD_EN == 0) begin
                        hazard = 1'b1;
                    end else if (s_mr[k] && (k < LOAD_LAT)) begin
                        hazard = 1'b1;
                    end else begin
                        sel[s] = SEL_W'(k + 1);
                    end
                end
            end
        end
    end

    assign fwd_sel1 = sel[0];
    assign fwd_sel2 = sel[1];

    // Slot shift register; frozen on mem_stall, bubble on stall or flush
    always_ff @(posedge clk) begin
        if (!rst) begin
            s_valid <= '0;
            s_wb    <= '0;
            s_mr    <= '0;
            s_dest  <= '0;
        end else if (!mem_stall) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                s_valid[k] <= s_valid[k-1];
                s_wb[k]    <= s_wb[k-1];
                s_mr[k]    <= s_mr[k-1];
                s_dest[k]  <= s_dest[k-1];
            end
            s_valid[0] <= id_valid & ~hazard & ~br_taken;
            s_wb[0]    <= id_wb_en;
            s_mr[0]    <= id_mem_read;
            s_dest[0]  <= id_dest;
        end
    end

    // Saturating stall and freeze cycle counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt  <= '0;
            freeze_cnt <= '0;
        end else begin
            if (hazard && !mem_stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (mem_stall && (freeze_cnt != '1))
                freeze_cnt <= freeze_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Random-stimulus bench for pipeline_scoreboard across three configs.
// Each instance is compared to a queue-based model of the in-flight set.
module tb_pipeline_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_use_src1, id_two_src, id_wb_en, id_mem_read;
    logic [3:0] id_src1, id_src2, id_dest;
    logic       br_taken, mem_stall;

    logic        haz [3];
    logic [1:0]  s1 [3];
    logic [1:0]  s2 [3];
    logic [15:0] sc0, fc0, sc1, fc1;
    logic [2:0]  sc2, fc2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipeline_scoreboard u0 (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_use_src1(id_use_src1), .id_two_src(id_two_src),
        .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
        .id_dest(id_dest), .br_taken(br_taken),
        .mem_stall(mem_stall), .hazard(haz[0]),
        .fwd_sel1(s1[0]), .fwd_sel2(s2[0]),
        .stall_cnt(sc0), .freeze_cnt(fc0)
    );

    pipeline_scoreboard #(.FWD_EN(0)) u1 (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_use_src1(id_use_src1), .id_two_src(id_two_src),
        .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
        .id_dest(id_dest), .br_taken(br_taken),
        .mem_stall(mem_stall), .hazard(haz[1]),
        .fwd_sel1(s1[1]), .fwd_sel2(s2[1]),
        .stall_cnt(sc1), .freeze_cnt(fc1)
    );

    pipeline_scoreboard #(.DEPTH(3), .LOAD_LAT(2), .CNT_W(3)) u2 (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_use_src1(id_use_src1), .id_two_src(id_two_src),
        .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
        .id_dest(id_dest), .br_taken(br_taken),
        .mem_stall(mem_stall), .hazard(haz[2]),
        .fwd_sel1(s1[2]), .fwd_sel2(s2[2]),
        .stall_cnt(sc2), .freeze_cnt(fc2)
    );

    typedef struct {
        bit       v;
        bit       wb;
        bit       mr;
        bit [3:0] d;
    } ent_t;

    // index 0 of each queue is the youngest in-flight instruction
    ent_t pipe [3][$];
    int   dep  [3] = '{2, 2, 3};
    int   fwd  [3] = '{1, 0, 1};
    int   lat  [3] = '{1, 1, 2};
    int   cmax [3] = '{65535, 65535, 7};
    int   m_sc [3];
    int   m_fc [3];

    task automatic chk(string tag, int got, int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic void pick(int i, bit used, bit [3:0] src,
                                 output bit h, output int sel);
        h   = 0;
        sel = 0;
        if (!(id_valid && used)) return;
        for (int j = 0; j < pipe[i].size(); j++) begin
            if (pipe[i][j].v && pipe[i][j].wb && pipe[i][j].d == src) begin
                if (fwd[i] == 0)                     h = 1;
                else if (pipe[i][j].mr && j < lat[i]) h = 1;
                else                                 sel = j + 1;
                return;
            end
        end
    endfunction

    function automatic void advance(int i, bit h);
        ent_t e;
        if (!rst) begin
            foreach (pipe[i][j]) pipe[i][j].v = 0;
            m_sc[i] = 0;
            m_fc[i] = 0;
        end else if (mem_stall) begin
            if (m_fc[i] < cmax[i]) m_fc[i]++;
        end else begin
            if (h && m_sc[i] < cmax[i]) m_sc[i]++;
            e.v  = id_valid && !h && !br_taken;
            e.wb = id_wb_en;
            e.mr = id_mem_read;
            e.d  = id_dest;
            pipe[i].push_front(e);
            void'(pipe[i].pop_back());
        end
    endfunction

    initial begin
        bit h1, h2;
        int e1, e2;
        int sc, fc;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < dep[i]; j++)
                pipe[i].push_back('{v: 0, wb: 0, mr: 0, d: 0});
            m_sc[i] = 0;
            m_fc[i] = 0;
        end
        rst = 0; id_valid = 0; id_use_src1 = 0; id_two_src = 0;
        id_wb_en = 0; id_mem_read = 0; id_src1 = 0; id_src2 = 0;
        id_dest = 0; br_taken = 0; mem_stall = 0;
        @(posedge clk);
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst         = (n < 2) ? 1'b0 : ($urandom_range(0, 249) != 0);
            id_valid    = ($urandom_range(0, 9) != 0);
            id_use_src1 = ($urandom_range(0, 4) != 0);
            id_two_src  = $urandom_range(0, 1) == 1;
            id_wb_en    = ($urandom_range(0, 4) != 0);
            id_mem_read = ($urandom_range(0, 9) < 3);
            id_src1     = 4'($urandom_range(0, 3));
            id_src2     = 4'($urandom_range(0, 3));
            id_dest     = 4'($urandom_range(0, 3));
            br_taken    = ($urandom_range(0, 9) == 0);
            mem_stall   = ($urandom_range(0, 6) == 0);
            #1;
            for (int i = 0; i < 3; i++) begin
                pick(i, id_use_src1, id_src1, h1, e1);
                pick(i, id_two_src, id_src2, h2, e2);
                sc = (i == 0) ? int'(sc0) : (i == 1) ? int'(sc1) : int'(sc2);
                fc = (i == 0) ? int'(fc0) : (i == 1) ? int'(fc1) : int'(fc2);
                chk($sformatf("u%0d.hazard", i), int'(haz[i]), int'(h1 | h2));
                chk($sformatf("u%0d.fwd_sel1", i), int'(s1[i]), e1);
                chk($sformatf("u%0d.fwd_sel2", i), int'(s2[i]), e2);
                chk($sformatf("u%0d.stall_cnt", i), sc, m_sc[i]);
                chk($sformatf("u%0d.freeze_cnt", i), fc, m_fc[i]);
                advance(i, h1 | h2);
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipeline_scoreboard.md
Name: pipeline_scoreboard

Overview:
- Parametrised hazard/forwarding scoreboard for the ARM pipeline; the successor to the fixed two-stage, stall-only hazard detection unit.
- Tracks up to DEPTH in-flight instructions past ID (slot 0 = EXE, slot 1 = MEM, …), each with its destination register, write-back enable and load flag.
- Issues stall (hazard) and per-source forward-select decisions for the instruction currently in ID.
- Supports forwarding or stall-only mode, configurable load-use latency, a global memory freeze, and saturating stall/freeze counters.

Parameters:
- REG_W, 4, register-address width (16 architectural registers).
- DEPTH, 2, number of tracked slots beyond ID whose results are not yet in the register file; must be >= 1.
- FWD_EN, 1, 1 = forward from slots, 0 = stall on any match (legacy behaviour).
- LOAD_LAT, 1, a load in slot k can forward only when k >= LOAD_LAT; otherwise stall. Range 0..DEPTH.
- CNT_W, 16, width of the performance counters.
- SEL_W, $clog2(DEPTH+1), derived; width of the forward selects.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_src1  in  REG_W  Rn address.
- id_src2  in  REG_W  Rm/Rd address.
- id_use_src1  in  1  instruction reads src1.
- id_two_src  in  1  instruction reads src2.
- id_wb_en  in  1  instruction writes id_dest.
- id_mem_read  in  1  instruction is a load.
- id_dest  in  REG_W  destination register.
- br_taken  in  1  branch resolved taken in EXE; the ID instruction is flushed.
- mem_stall  in  1  memory wait; whole pipeline frozen.
- hazard  out  1  stall IF/ID and insert a bubble into ID/EXE.
- fwd_sel1  out  SEL_W  0 = register file, k = value from slot k-1.
- fwd_sel2  out  SEL_W  same encoding for src2.
- stall_cnt  out  CNT_W  cycles with hazard=1 and mem_stall=0.
- freeze_cnt  out  CNT_W  cycles with mem_stall=1.

Behaviour:
- State: DEPTH slots, each {valid, wb_en, mem_read, dest}. All registered.
- Reset (rst=0 at a clk edge): all slots invalid; stall_cnt = 0; freeze_cnt = 0. Outputs after reset: hazard=0, fwd_sel1=0, fwd_sel2=0.
- Match for source s in slot k: slot valid & wb_en & dest==s & source used (src1 requires id_use_src1; src2 requires id_two_src) & id_valid.
- FWD_EN=0:
  - hazard = any match on either source in any slot.
  - fwd_sel1 and fwd_sel2 are constant 0.
- FWD_EN=1, per source:
  - Pick the lowest-k matching slot (youngest wins).
  - If that slot has mem_read and k < LOAD_LAT: hazard=1, sel=0.
  - Otherwise sel = k+1.
  - No match: sel=0.
  - hazard = OR over both sources.
- hazard and the sels are combinational from current slot state and ID inputs (same-cycle decision, no added latency).
- Slot update at each clk edge, in priority order:
  1. Reset.
  2. mem_stall=1: all slots hold; br_taken is ignored (upstream holds it).
  3. Otherwise shift slot k -> slot k+1; the last slot drops out.
  4. Slot 0 receives the ID instruction only if id_valid & !hazard & !br_taken; otherwise slot 0 becomes a bubble (valid=0).
- br_taken and hazard in the same cycle: the flush wins (bubble); hazard is still reported, but the bubble is identical either way.
- Instruction with wb_en=0 or dest unused: it occupies a slot but never matches.
- Counters:
  - stall_cnt increments when hazard & !mem_stall.
  - freeze_cnt increments when mem_stall.
  - Both saturate at 2^CNT_W - 1 (no wrap). Reset clears them mid-count.
- Reset mid-operation discards all in-flight entries; the first post-reset ID instruction sees no hazards.

Test Plan:
- Defaults: issue ADD R1 (wb, dest=1), then SUB reading src1=1 -> SUB sees fwd_sel1=1, hazard=0. One cycle later, a reader of R1 sees fwd_sel1=2. Next cycle, fwd_sel1=0.
- Defaults: LDR R2, then ADD with src2=2, two_src=1 -> hazard=1 for exactly 1 cycle, stall_cnt 0->1. Then fwd_sel2=2, hazard=0.
- FWD_EN=0: ADD R3, then ORR using R3 -> hazard=1 for 2 cycles, then 0; stall_cnt=2; sels stay 0.
- Both slots write R4, reader of R4 -> fwd_sel1=1 (youngest wins). Same reader with id_use_src1=0 -> sel=0, hazard=0.
- mem_stall=1 for 3 cycles with a pending load match -> slots frozen, hazard held at 1, stall_cnt unchanged, freeze_cnt=3. br_taken pulsed during the stall has no effect.
- br_taken with ID=ADD R5 -> slot 0 is a bubble; next reader of R5 sees no match. Assert rst=0 for one cycle with slots full -> all sels 0, hazard=0, counters 0.
